// File: rtl/udma_eth_pkg.sv
// Shared types for the Ethernet TX descriptor scheduler: FSM states, descriptor
// layout and the frame-length limit.
package udma_eth_pkg;

  localparam int ETH_MAX_LEN = 1518;
  localparam int ETH_LEN_W   = 11;
  localparam int ETH_ADDR_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_STREAM,
    ST_DONE
  } eth_tx_state_e;

  typedef struct packed {
    logic [ETH_ADDR_W-1:0] addr;
    logic [ETH_LEN_W-1:0]  len;
  } eth_desc_t;

  function automatic logic len_ok(input logic [ETH_LEN_W-1:0] len, input int max_len);
    return (len != '0) && (32'(len) <= 32'(max_len));
  endfunction

endpackage

// File: rtl/udma_eth_desc_fifo.sv
// Synchronous descriptor FIFO with flush; push is ignored when full and pop
// when empty, so callers may drive them unconditionally.
module udma_eth_desc_fifo
  import udma_eth_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  eth_desc_t                    data_i,
  input  logic                         pop_i,
  output eth_desc_t                    data_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  eth_desc_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      level_q <= level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/udma_eth_tx_scheduler.sv
// Queues TX frame descriptors, launches one uDMA transfer per frame and
// forwards the returned byte stream to the MAC with tlast on the final byte.
module udma_eth_tx_scheduler
  import udma_eth_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int QUEUE_DEPTH    = 4,
  parameter int MAX_LEN        = ETH_MAX_LEN
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_rst_i,
  input  logic [L2_AWIDTH_NOAL-1:0] reg_tx_startaddr_i,
  input  logic [10:0]               reg_tx_len_i,
  input  logic                      reg_tx_push_i,
  input  logic                      reg_tx_clr_i,
  output logic [2:0]                reg_tx_level_o,
  output logic                      reg_tx_full_o,
  output logic                      reg_tx_busy_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_tx_size_o,
  output logic [1:0]                cfg_tx_datasize_o,
  output logic                      cfg_tx_en_o,
  output logic                      cfg_tx_clr_o,
  input  logic                      cfg_tx_pending_i,
  input  logic [7:0]                tx_data_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  output logic [7:0]                m_axis_tdata_o,
  output logic                      m_axis_tvalid_o,
  output logic                      m_axis_tlast_o,
  input  logic                      m_axis_tready_i,
  output logic                      eth_tx_event_o,
  output logic                      eth_error_event_o
);

  eth_tx_state_e             state_q;
  logic [10:0]               cnt_q, cur_len_q;
  logic [L2_AWIDTH_NOAL-1:0] cfg_addr_q;
  logic [TRANS_SIZE-1:0]     cfg_size_q;
  logic                      cfg_en_q, cfg_clr_q, evt_q, err_q;

  eth_desc_t                      desc_in, head;
  logic [$clog2(QUEUE_DEPTH+1)-1:0] fifo_level;
  logic fifo_full, fifo_empty, push_acc, push_bad, pop, stream, beat, last;
  logic head_addr_unused;

  assign desc_in  = '{addr: ETH_ADDR_W'(reg_tx_startaddr_i), len: reg_tx_len_i};
  // A clear swallows any same-cycle push silently; otherwise bad pushes raise an error.
  assign push_acc = reg_tx_push_i && !reg_tx_clr_i && len_ok(reg_tx_len_i, MAX_LEN) && !fifo_full;
  assign push_bad = reg_tx_push_i && !reg_tx_clr_i && !(len_ok(reg_tx_len_i, MAX_LEN) && !fifo_full);
  assign pop      = (state_q == ST_IDLE) && !fifo_empty && !cfg_tx_pending_i && !reg_tx_clr_i;

  udma_eth_desc_fifo #(.DEPTH(QUEUE_DEPTH)) u_desc_fifo (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .flush_i (reg_tx_clr_i),
    .push_i  (push_acc),
    .data_i  (desc_in),
    .pop_i   (pop),
    .data_o  (head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_addr_unused = ^head.addr;

  // Valid/ready: a byte moves only in STREAM, on a cycle where tx_valid_i and
  // m_axis_tready_i are both high; tx_ready_o mirrors tready so both sides agree.
  assign stream          = (state_q == ST_STREAM);
  assign beat            = stream && tx_valid_i && m_axis_tready_i;
  assign last            = stream && (cnt_q == cur_len_q - 11'd1);
  assign m_axis_tdata_o  = stream ? tx_data_i : '0;
  assign m_axis_tvalid_o = stream && tx_valid_i;
  assign tx_ready_o      = stream && m_axis_tready_i;
  assign m_axis_tlast_o  = last;

  assign reg_tx_level_o     = 3'(fifo_level);
  assign reg_tx_full_o      = fifo_full;
  assign reg_tx_busy_o      = (state_q != ST_IDLE);
  assign cfg_tx_startaddr_o = cfg_addr_q;
  assign cfg_tx_size_o      = cfg_size_q;
  assign cfg_tx_datasize_o  = 2'b00;
  assign cfg_tx_en_o        = cfg_en_q;
  assign cfg_tx_clr_o       = cfg_clr_q;
  assign eth_tx_event_o     = evt_q;
  assign eth_error_event_o  = err_q;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cur_len_q  <= '0;
      cfg_addr_q <= '0;
      cfg_size_q <= '0;
      cfg_en_q   <= 1'b0;
      cfg_clr_q  <= 1'b0;
      evt_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cfg_en_q  <= 1'b0;
      evt_q     <= 1'b0;
      cfg_clr_q <= reg_tx_clr_i;
      err_q     <= push_bad ||
                   (reg_tx_clr_i && (state_q == ST_LAUNCH || state_q == ST_STREAM));
      if (reg_tx_clr_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: if (pop) begin
            cfg_addr_q <= head.addr[L2_AWIDTH_NOAL-1:0];
            cfg_size_q <= TRANS_SIZE'(head.len);
            cur_len_q  <= head.len;
            cfg_en_q   <= 1'b1;
            state_q    <= ST_LAUNCH;
          end
          ST_LAUNCH: begin
            cnt_q   <= '0;
            state_q <= ST_STREAM;
          end
          ST_STREAM: if (beat) begin
            cnt_q <= cnt_q + 11'd1;
            if (last) begin
              evt_q   <= 1'b1;
              state_q <= ST_DONE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udma_eth_tx_scheduler.sv
// Directed and randomized checks of the TX scheduler against a descriptor-queue
// model and per-frame beat expectations.
module tb_udma_eth_tx_scheduler;

  logic        sys_clk_i = 1'b0;
  logic        sys_rst_i;
  logic [11:0] reg_tx_startaddr_i;
  logic [10:0] reg_tx_len_i;
  logic        reg_tx_push_i, reg_tx_clr_i;
  logic [2:0]  reg_tx_level_o;
  logic        reg_tx_full_o, reg_tx_busy_o;
  logic [11:0] cfg_tx_startaddr_o;
  logic [15:0] cfg_tx_size_o;
  logic [1:0]  cfg_tx_datasize_o;
  logic        cfg_tx_en_o, cfg_tx_clr_o, cfg_tx_pending_i;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i, tx_ready_o;
  logic [7:0]  m_axis_tdata_o;
  logic        m_axis_tvalid_o, m_axis_tlast_o, m_axis_tready_i;
  logic        eth_tx_event_o, eth_error_event_o;

  udma_eth_tx_scheduler dut (
    .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i),
    .reg_tx_startaddr_i(reg_tx_startaddr_i), .reg_tx_len_i(reg_tx_len_i),
    .reg_tx_push_i(reg_tx_push_i), .reg_tx_clr_i(reg_tx_clr_i),
    .reg_tx_level_o(reg_tx_level_o), .reg_tx_full_o(reg_tx_full_o),
    .reg_tx_busy_o(reg_tx_busy_o), .cfg_tx_startaddr_o(cfg_tx_startaddr_o),
    .cfg_tx_size_o(cfg_tx_size_o), .cfg_tx_datasize_o(cfg_tx_datasize_o),
    .cfg_tx_en_o(cfg_tx_en_o), .cfg_tx_clr_o(cfg_tx_clr_o),
    .cfg_tx_pending_i(cfg_tx_pending_i), .tx_data_i(tx_data_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .m_axis_tdata_o(m_axis_tdata_o), .m_axis_tvalid_o(m_axis_tvalid_o),
    .m_axis_tlast_o(m_axis_tlast_o), .m_axis_tready_i(m_axis_tready_i),
    .eth_tx_event_o(eth_tx_event_o), .eth_error_event_o(eth_error_event_o)
  );

  // clock / reset
  always #5 sys_clk_i = ~sys_clk_i;

  int n_asserts = 0, n_fail = 0;
  int en_cnt = 0, evt_cnt = 0, err_cnt = 0, clr_cnt = 0;
  int exp_en = 0, exp_evt = 0, exp_err = 0, exp_clr = 0;
  logic [22:0] exp_q[$];  // {addr, len} of descriptors the scheduler should hold

  always @(negedge sys_clk_i) begin
    if (sys_rst_i === 1'b0) begin
      if (cfg_tx_en_o === 1'b1)       en_cnt++;
      if (eth_tx_event_o === 1'b1)    evt_cnt++;
      if (eth_error_event_o === 1'b1) err_cnt++;
      if (cfg_tx_clr_o === 1'b1)      clr_cnt++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk_i); #1;
      tx_valid_i = 1'b0;
    end
    @(negedge sys_clk_i);
  endtask

  // Push one descriptor while the scheduler is held off, so the model level is exact.
  task automatic push_desc(input logic [11:0] a, input int len);
    logic [10:0] l11;
    bit ok;
    l11 = len[10:0];
    ok  = (l11 >= 11'd1) && (l11 <= 11'd1518) && (exp_q.size() < 4);
    @(posedge sys_clk_i); #1;
    reg_tx_push_i = 1'b1; reg_tx_startaddr_i = a; reg_tx_len_i = l11;
    @(negedge sys_clk_i);
    @(posedge sys_clk_i); #1;
    reg_tx_push_i = 1'b0;
    @(negedge sys_clk_i);
    check("push_err_pulse", eth_error_event_o, !ok);
    if (ok) exp_q.push_back({a, l11});
    else    exp_err++;
    check("push_level", reg_tx_level_o, exp_q.size());
    check("push_full", reg_tx_full_o, exp_q.size() == 4);
  endtask

  task automatic wait_en(output bit got, output int w);
    got = 1'b0;
    for (w = 0; w < 64; w++) begin
      @(posedge sys_clk_i); #1;
      tx_valid_i = 1'b0; m_axis_tready_i = 1'b1;
      @(negedge sys_clk_i);
      if (cfg_tx_en_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("en_seen", got, 1);
    if (got) exp_en++;
  endtask

  // flow 0: full rate, 1: random valid/ready, 2: valid held, tready toggling
  task automatic run_frame(input int exp_wait, input int flow);
    logic [22:0] d;
    logic [11:0] a;
    int ln, beat, w;
    bit got, v, r;
    logic [7:0] data;
    d = exp_q.pop_front();
    a = d[22:11];
    ln = int'(d[10:0]);
    wait_en(got, w);
    if (!got) return;
    if (exp_wait >= 0) check("launch_gap", w, exp_wait);
    check("cfg_addr", cfg_tx_startaddr_o, a);
    check("cfg_size", cfg_tx_size_o, ln);
    check("cfg_datasize", cfg_tx_datasize_o, 0);
    check("launch_busy", reg_tx_busy_o, 1);
    check("launch_tvalid", m_axis_tvalid_o, 0);
    check("launch_txready", tx_ready_o, 0);
    beat = 0;
    for (int c = 0; c < 8000 && beat < ln; c++) begin
      @(posedge sys_clk_i); #1;
      case (flow)
        0: begin v = 1'b1; r = 1'b1; end
        1: begin v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) != 0); end
        default: begin v = 1'b1; r = c[0]; end
      endcase
      data = 8'($urandom);
      tx_valid_i = v; m_axis_tready_i = r; tx_data_i = data;
      @(negedge sys_clk_i);
      check("stream_tvalid", m_axis_tvalid_o, v);
      check("stream_txready", tx_ready_o, r);
      check("stream_tlast", m_axis_tlast_o, beat == ln - 1);
      if (v && r) begin
        check("stream_tdata", m_axis_tdata_o, data);
        beat++;
      end
    end
    check("frame_beats", beat, ln);
    @(posedge sys_clk_i); #1;
    tx_valid_i = 1'b0;
    @(negedge sys_clk_i);
    check("done_event", eth_tx_event_o, 1);
    check("done_busy", reg_tx_busy_o, 1);
    check("done_tvalid", m_axis_tvalid_o, 0);
    exp_evt++;
  endtask

  initial begin
    bit got;
    int w, n, len;
    logic [7:0] data;
    sys_rst_i = 1'b1; reg_tx_startaddr_i = '0; reg_tx_len_i = '0;
    reg_tx_push_i = 1'b0; reg_tx_clr_i = 1'b0; cfg_tx_pending_i = 1'b1;
    tx_data_i = '0; tx_valid_i = 1'b1; m_axis_tready_i = 1'b1;
    repeat (3) @(posedge sys_clk_i);
    @(negedge sys_clk_i);
    check("rst_addr", cfg_tx_startaddr_o, 0);
    check("rst_size", cfg_tx_size_o, 0);
    check("rst_en", cfg_tx_en_o, 0);
    check("rst_clr", cfg_tx_clr_o, 0);
    check("rst_evt", eth_tx_event_o, 0);
    check("rst_err", eth_error_event_o, 0);
    check("rst_tvalid", m_axis_tvalid_o, 0);
    check("rst_txready", tx_ready_o, 0);
    check("rst_tlast", m_axis_tlast_o, 0);
    check("rst_full", reg_tx_full_o, 0);
    check("rst_busy", reg_tx_busy_o, 0);
    check("rst_level", reg_tx_level_o, 0);
    @(posedge sys_clk_i); #1;
    sys_rst_i = 1'b0; tx_valid_i = 1'b0;

    // single 64-byte frame
    push_desc(12'h100, 64);
    cfg_tx_pending_i = 1'b0;
    run_frame(-1, 0);
    cfg_tx_pending_i = 1'b1;

    // fill past depth, then drain in order with minimum gaps
    for (int i = 0; i < 5; i++) push_desc(12'h200 + 12'(i * 16), 8 + i);
    cfg_tx_pending_i = 1'b0;
    run_frame(-1, 1);
    for (int i = 0; i < 3; i++) run_frame(1, 1);
    cfg_tx_pending_i = 1'b1;

    // illegal lengths
    push_desc(12'h010, 0);
    push_desc(12'h020, 1519);
    cfg_tx_pending_i = 1'b0;
    idle_cycles(10);
    check("bad_len_no_launch", en_cnt, exp_en);
    cfg_tx_pending_i = 1'b1;

    // one-byte frame with tready toggling, then the longest legal frame
    push_desc(12'h3F0, 1);
    cfg_tx_pending_i = 1'b0;
    run_frame(-1, 2);
    cfg_tx_pending_i = 1'b1;
    push_desc(12'h7FF, 1518);
    cfg_tx_pending_i = 1'b0;
    run_frame(-1, 0);
    cfg_tx_pending_i = 1'b1;

    // channel pending holds the scheduler in IDLE
    push_desc(12'h123, 5);
    for (int i = 0; i < 5; i++) begin
      idle_cycles(1);
      check("pending_busy", reg_tx_busy_o, 0);
      check("pending_level", reg_tx_level_o, 1);
    end
    @(posedge sys_clk_i); #1;
    cfg_tx_pending_i = 1'b0;
    @(negedge sys_clk_i);
    check("pending_pop_no_en", cfg_tx_en_o, 0);
    run_frame(0, 0);
    cfg_tx_pending_i = 1'b1;

    // clear during beat 10 of a 100-byte frame with two more queued
    push_desc(12'h400, 100);
    push_desc(12'h500, 20);
    push_desc(12'h600, 30);
    cfg_tx_pending_i = 1'b0;
    void'(exp_q.pop_front());
    wait_en(got, w);
    for (int i = 0; i < 10; i++) begin
      @(posedge sys_clk_i); #1;
      data = 8'($urandom);
      tx_valid_i = 1'b1; m_axis_tready_i = 1'b1; tx_data_i = data;
      @(negedge sys_clk_i);
      check("clr_stream_tdata", m_axis_tdata_o, data);
    end
    @(posedge sys_clk_i); #1;
    reg_tx_clr_i = 1'b1;
    @(negedge sys_clk_i);
    @(posedge sys_clk_i); #1;
    reg_tx_clr_i = 1'b0;
    @(negedge sys_clk_i);
    check("clr_pulse", cfg_tx_clr_o, 1);
    check("clr_err", eth_error_event_o, 1);
    check("clr_level", reg_tx_level_o, 0);
    check("clr_busy", reg_tx_busy_o, 0);
    check("clr_tvalid", m_axis_tvalid_o, 0);
    exp_clr++; exp_err++;
    exp_q.delete();
    idle_cycles(10);
    check("clr_no_launch", en_cnt, exp_en);
    cfg_tx_pending_i = 1'b1;

    // clear in IDLE beats a same-cycle push and raises no error
    @(posedge sys_clk_i); #1;
    reg_tx_push_i = 1'b1; reg_tx_len_i = 11'd10; reg_tx_clr_i = 1'b1;
    @(negedge sys_clk_i);
    @(posedge sys_clk_i); #1;
    reg_tx_push_i = 1'b0; reg_tx_clr_i = 1'b0;
    @(negedge sys_clk_i);
    check("clr_push_pulse", cfg_tx_clr_o, 1);
    check("clr_push_err", eth_error_event_o, 0);
    check("clr_push_level", reg_tx_level_o, 0);
    exp_clr++;

    // randomized batches
    for (int round = 0; round < 6; round++) begin
      cfg_tx_pending_i = 1'b1;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0) len = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1519, 2047);
        else                           len = $urandom_range(1, 24);
        push_desc(12'($urandom), len);
      end
      cfg_tx_pending_i = 1'b0;
      for (int k = 0; exp_q.size() > 0; k++) run_frame((k == 0) ? -1 : 1, 1);
    end

    // reset mid-frame abandons silently
    cfg_tx_pending_i = 1'b1;
    push_desc(12'h0AA, 50);
    cfg_tx_pending_i = 1'b0;
    void'(exp_q.pop_front());
    wait_en(got, w);
    for (int i = 0; i < 5; i++) begin
      @(posedge sys_clk_i); #1;
      tx_valid_i = 1'b1; m_axis_tready_i = 1'b1;
    end
    @(posedge sys_clk_i); #1;
    sys_rst_i = 1'b1;
    repeat (2) @(posedge sys_clk_i);
    @(negedge sys_clk_i);
    check("midrst_busy", reg_tx_busy_o, 0);
    check("midrst_tvalid", m_axis_tvalid_o, 0);
    check("midrst_level", reg_tx_level_o, 0);
    @(posedge sys_clk_i); #1;
    sys_rst_i = 1'b0;
    idle_cycles(8);

    check("total_launches", en_cnt, exp_en);
    check("total_tx_events", evt_cnt, exp_evt);
    check("total_err_events", err_cnt, exp_err);
    check("total_clr_pulses", clr_cnt, exp_clr);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
